lock_entry_ctrl: RTL and testbench



---
 rtl/lock_pkg.sv | 27 ++
 rtl/lock_entry_ctrl_debounce.sv | 46 ++++
 rtl/lock_entry_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lock_entry_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and default timing for the lock entry front-end.
// Imported by the debouncer and the entry sequencer.
package lock_pkg;

    localparam int CODE_W = 4;

    localparam int DEF_DEB_CYCLES  = 16;
    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_CMP_HOLD    = 8;
    localparam int DEF_SET_HOLD    = 4;
    localparam int DEF_RESULT_HOLD = 1000;

    typedef enum logic [2:0] {
        IDLE,
        CMP_SETUP,
        COMPARE,
        SET_SETUP,
        SET,
        RESULT,
        LOCKOUT
    } state_t;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_entry_ctrl_debounce.sv
// Counter debouncer: level follows raw only after DEB_CYCLES
// consecutive differing samples; rise pulses for one cycle on accept.
module debounce
#(
    parameter int DEB_CYCLES = 16
)
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (DEB_CYCLES > 0)
                else $error("debounce: DEB_CYCLES must be > 0");
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= raw;
                r_rise  <= raw;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/lock_entry_ctrl.sv
// Operator-side sequencer for the combination lock: debounced entry,
// timed compare/program strobes, result and lockout reporting.
module lock_entry_ctrl
    import lock_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int CMP_HOLD     = DEF_CMP_HOLD,
    parameter int SET_HOLD     = DEF_SET_HOLD,
    parameter int RESULT_HOLD  = DEF_RESULT_HOLD
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] key_in,
    input  logic              submit_btn,
    input  logic              set_btn,
    input  logic              lock_open,
    input  logic              lock_alert,
    output logic [CODE_W-1:0] code_out,
    output logic              cmp_en,
    output logic              set_en,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic              lockout
);

    localparam int CNT_MAX = max_of(max_of(SETUP_CYCLES, CMP_HOLD),
                                    max_of(SET_HOLD, RESULT_HOLD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMP_LAST    = CNT_W'(CMP_HOLD - 1);
    localparam logic [CNT_W-1:0] SET_LAST    = CNT_W'(SET_HOLD - 1);
    localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_HOLD - 1);

    localparam int N_RAW = CODE_W + 2;

    logic [N_RAW-1:0]  w_raw;
    logic [N_RAW-1:0]  w_lvl;
    logic [N_RAW-1:0]  w_rise;
    logic [CODE_W-1:0] w_key_lvl;
    logic              w_sub_req;
    logic              w_set_req;
    logic              w_unused;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_cmp_en;
    logic              r_set_en;
    logic              r_busy;
    logic              r_pass;
    logic              r_fail;
    logic              r_lockout;
    logic              r_from_lock;

    assign w_raw = {set_btn, submit_btn, key_in};

    for (genvar g = 0; g < N_RAW; g++) begin : g_deb
        debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (w_raw[g]),
            .level (w_lvl[g]),
            .rise  (w_rise[g])
        );
    end

    assign w_key_lvl = w_lvl[CODE_W-1:0];
    assign w_sub_req = w_rise[CODE_W];
    assign w_set_req = w_rise[CODE_W+1];
    assign w_unused  = ^{w_rise[CODE_W-1:0], w_lvl[N_RAW-1:CODE_W]};

    // Alert preempts everything except an in-progress program cycle,
    // which is what clears the core's timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (SETUP_CYCLES > 0 && CMP_HOLD > 0 &&
                    SET_HOLD > 0 && RESULT_HOLD > 0)
                else $error("lock_entry_ctrl: count parameters must be > 0");
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_code      <= '0;
            r_cmp_en    <= 1'b0;
            r_set_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_lockout   <= 1'b0;
            r_from_lock <= 1'b0;
        end else if (lock_alert && r_state != SET_SETUP &&
                     r_state != SET && r_state != LOCKOUT) begin
            r_state   <= LOCKOUT;
            r_cnt     <= '0;
            r_cmp_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_lockout <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_set_req) begin
                        r_state     <= SET_SETUP;
                        r_code      <= w_key_lvl;
                        r_from_lock <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_cnt       <= '0;
                    end else if (w_sub_req) begin
                        r_state <= CMP_SETUP;
                        r_code  <= w_key_lvl;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_fail  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                CMP_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state  <= COMPARE;
                        r_cnt    <= '0;
                        r_cmp_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                COMPARE: begin
                    if (r_cnt == CMP_LAST) begin
                        r_state  <= RESULT;
                        r_cnt    <= '0;
                        r_cmp_en <= 1'b0;
                        r_pass   <= lock_open;
                        r_fail   <= ~lock_open;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SET_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_state  <= SET;
                        r_cnt    <= '0;
                        r_set_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SET: begin
                    if (r_cnt == SET_LAST) begin
                        r_state  <= r_from_lock ? LOCKOUT : IDLE;
                        r_cnt    <= '0;
                        r_set_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (r_cnt == RESULT_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (!lock_alert) begin
                        r_state   <= IDLE;
                        r_lockout <= 1'b0;
                    end else if (w_set_req) begin
                        r_state     <= SET_SETUP;
                        r_code      <= w_key_lvl;
                        r_from_lock <= 1'b1;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign code_out = r_code;
    assign cmp_en   = r_cmp_en;
    assign set_en   = r_set_en;
    assign busy     = r_busy;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign lockout  = r_lockout;

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl with short debounce and result hold.
module tb_lock_entry_ctrl;
    import lock_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       submit_btn;
    logic       set_btn;
    logic       lock_open;
    logic       lock_alert;
    logic [3:0] code_out;
    logic       cmp_en;
    logic       set_en;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       lockout;

    int n_chk = 0;
    int n_bad = 0;

    int cyc = 0;
    int m_cmp, m_cmp_rise, m_set, m_set_rise, m_both;
    int t_busy = 0;
    int t_cmp = 0;
    logic p_cmp = 1'b0;
    logic p_set = 1'b0;
    logic p_busy = 1'b0;

    lock_entry_ctrl #(
        .DEB_CYCLES   (4),
        .SETUP_CYCLES (2),
        .CMP_HOLD     (8),
        .SET_HOLD     (4),
        .RESULT_HOLD  (20)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .submit_btn (submit_btn),
        .set_btn    (set_btn),
        .lock_open  (lock_open),
        .lock_alert (lock_alert),
        .code_out   (code_out),
        .cmp_en     (cmp_en),
        .set_en     (set_en),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .lockout    (lockout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        m_cmp = 0;
        m_cmp_rise = 0;
        m_set = 0;
        m_set_rise = 0;
        m_both = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cmp_en) m_cmp++;
        if (set_en) m_set++;
        if (cmp_en && !p_cmp) begin
            m_cmp_rise++;
            t_cmp = cyc;
        end
        if (set_en && !p_set) m_set_rise++;
        if (busy && !p_busy) t_busy = cyc;
        if (cmp_en && set_en) m_both++;
        p_cmp = cmp_en;
        p_set = set_en;
        p_busy = busy;
    endtask

    task automatic press(input logic sub, input logic st);
        submit_btn = sub;
        set_btn = st;
        repeat (6) step();
        submit_btn = 1'b0;
        set_btn = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int k = 0;
        while (!busy && k < 40) begin
            step();
            k++;
        end
        check(tag, busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_cmp(input string tag);
        int k = 0;
        while (!cmp_en && k < 40) begin
            step();
            k++;
        end
        check(tag, cmp_en, 1);
    endtask

    initial begin
        clr();
        // reset with every debounced raw input high
        rst = 1'b1;
        key_in = 4'hF;
        submit_btn = 1'b1;
        set_btn = 1'b1;
        lock_open = 1'b0;
        lock_alert = 1'b0;
        repeat (3) step();
        check("rst_outs", {code_out, cmp_en, set_en, busy,
                           pass, fail, lockout}, 0);
        check("rst_state", u_dut.r_state, IDLE);
        check("rst_deb", u_dut.w_lvl, 0);
        rst = 1'b0;
        clr();
        repeat (3) step();
        check("deb_early", u_dut.w_lvl, 0);
        step();
        check("deb_rise", u_dut.w_lvl, 6'h3F);
        step();
        check("t1_code", code_out, 4'hF);
        check("t1_busy", busy, 1);
        submit_btn = 1'b0;
        set_btn = 1'b0;
        wait_idle("t1_idle");
        check("t1_set_len", m_set, 4);
        check("t1_no_cmp", m_cmp, 0);
        repeat (10) step();

        // compare that opens the lock
        key_in = 4'hA;
        lock_open = 1'b1;
        repeat (8) step();
        clr();
        press(1'b1, 1'b0);
        wait_busy("t2_busy");
        check("t2_code", code_out, 4'hA);
        wait_idle("t2_idle");
        check("t2_cmp_len", m_cmp, 8);
        check("t2_cmp_pulses", m_cmp_rise, 1);
        check("t2_setup", t_cmp - t_busy, 2);
        check("t2_passfail", {pass, fail}, 2'b10);
        check("t2_no_set", m_set, 0);

        // rejected compare, key changes mid-compare
        lock_open = 1'b0;
        repeat (10) step();
        clr();
        press(1'b1, 1'b0);
        wait_cmp("t3_cmp");
        key_in = 4'h5;
        wait_idle("t3_idle");
        check("t3_code_held", code_out, 4'hA);
        check("t3_passfail", {pass, fail}, 2'b01);
        check("t3_cmp_len", m_cmp, 8);
        repeat (20) step();
        check("t3_one_pulse", m_cmp_rise, 1);

        // set and submit accepted on the same cycle
        check("t4_pre_fail", fail, 1);
        key_in = 4'h3;
        repeat (8) step();
        clr();
        press(1'b1, 1'b1);
        wait_busy("t4_busy");
        check("t4_code", code_out, 4'h3);
        wait_idle("t4_idle");
        check("t4_set_len", m_set, 4);
        check("t4_set_pulses", m_set_rise, 1);
        check("t4_no_cmp", m_cmp, 0);
        check("t4_passfail", {pass, fail}, 2'b00);
        check("t4_exclusive", m_both, 0);

        // alert during compare, lockout handling
        lock_open = 1'b1;
        repeat (10) step();
        clr();
        press(1'b1, 1'b0);
        wait_cmp("t5_cmp");
        step();
        step();
        lock_alert = 1'b1;
        step();
        check("t5_cmp_drop", cmp_en, 0);
        check("t5_lockout", lockout, 1);
        check("t5_cmp_len", m_cmp, 3);
        check("t5_passfail", {pass, fail}, 2'b00);
        check("t5_not_busy", busy, 0);
        press(1'b1, 1'b0);
        repeat (10) step();
        check("t5_sub_ign", m_cmp_rise, 1);
        check("t5_sub_idle", busy, 0);
        clr();
        press(1'b0, 1'b1);
        wait_idle("t5_set_done");
        check("t5_set_len", m_set, 4);
        check("t5_back_lock", lockout, 1);
        check("t5_lock_state", u_dut.r_state, LOCKOUT);
        lock_alert = 1'b0;
        step();
        check("t5_exit", lockout, 0);
        check("t5_exit_state", u_dut.r_state, IDLE);

        // bouncing submit gives one compare
        repeat (10) step();
        clr();
        for (int i = 0; i < 10; i++) begin
            submit_btn = (i % 2 == 0);
            step();
            step();
        end
        submit_btn = 1'b1;
        repeat (10) step();
        submit_btn = 1'b0;
        repeat (80) step();
        check("t6_one_cmp", m_cmp_rise, 1);
        check("t6_cmp_len", m_cmp, 8);
        check("t6_idle", busy, 0);
        check("t6_pass", pass, 1);

        // reset mid-compare abandons the attempt
        lock_open = 1'b1;
        repeat (10) step();
        clr();
        press(1'b1, 1'b0);
        wait_cmp("t7_cmp");
        rst = 1'b1;
        step();
        check("t7_cmp_drop", cmp_en, 0);
        check("t7_busy", busy, 0);
        rst = 1'b0;
        repeat (40) step();
        check("t7_no_more", m_cmp, 1);
        check("t7_no_pass", {pass, fail}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_chk, n_bad);
        $finish;
    end

endmodule
